cpu6_lsu: RTL and testbench
===========================

Name: cpu6_lsu

Overview:
- Memory-stage load/store unit. Consumes the M-stage control and data registered by the EX/MEM pipeline register, issues one data-bus transaction per memory instruction, and stalls the pipeline until the bus responds.
- Produces aligned, sign- or zero-extended load data for the MEM/WB register, byte enables and replicated write data for stores, and a misalignment exception flag.

Parameters:
XLEN, 32, data/address width (only 32 supported)
SIZE_W, 2, access-size code width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
memwriteM  in  1  store in M stage
memtoregM  in  1  load in M stage
aluoutM  in  XLEN  effective byte address
writedataM  in  XLEN  store data (low bits significant)
memsizeM  in  SIZE_W  00 byte, 01 half, 10 word, 11 reserved (treated as word)
memunsignedM  in  1  zero-extend load (LBU/LHU)
stallM  out  1  hold PC/IF/ID/EX and EX/MEM registers
lsu_doneM  out  1  one-cycle pulse: memory op completed, result valid
lsu_rdataM  out  XLEN  extended load data, valid while lsu_doneM=1
excp_misalignM  out  1  misaligned access, valid same cycle op appears
dbus_req  out  1  bus request
dbus_we  out  1  1=write
dbus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dbus_be  out  4  byte enables
dbus_wdata  out  XLEN  lane-replicated store data
dbus_gnt  in  1  request accepted this cycle
dbus_rvalid  in  1  response (read data or write ack)
dbus_rdata  in  XLEN  read data

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE; all capture registers cleared. While in IDLE with no op: stallM, lsu_doneM, excp_misalignM, dbus_req all 0; lsu_rdataM=0.
- memop = memwriteM | memtoregM. If both are set, the op is a store. The load path is ignored.
- Misalign: half with addr[0]=1, or word/reserved with addr[1:0]!=0.
  - Asserted combinationally in IDLE when memop.
  - No request issued; stallM=0; lsu_doneM=0; state stays IDLE.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE, aligned memop:
    - Drive dbus_req=1 and the address/be/wdata/we fields from the M inputs, with stallM=1.
    - Capture addr[1:0], size, unsigned and we.
    - Next state is WAIT if dbus_gnt=1, else REQ.
  - REQ: dbus_req=1 with fields driven from the captured copies, held stable until gnt. stallM=1. On gnt go to WAIT.
  - WAIT: dbus_req=0, stallM=1. On dbus_rvalid, register the extended load data (0 for stores) and go to DONE.
  - DONE: stallM=0, lsu_doneM=1, lsu_rdataM valid. No request issued. Next state is IDLE.
  - The next instruction enters M at the following edge. A back-to-back memop is issued from IDLE on the cycle after DONE.
- Minimum latency (gnt in the issue cycle, rvalid in the next cycle): three cycles in M, two of them stalled.
- dbus_rvalid is ignored in IDLE, REQ and DONE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Write data:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load extraction: shifted = dbus_rdata >> (addr[1:0]*8), then:
  - byte: sign- or zero-extend shifted[7:0]
  - half: sign- or zero-extend shifted[15:0]
  - word: unchanged
- Inputs may change during REQ/WAIT; the captured copies govern. The pipeline is stalled, so the inputs should be stable anyway.
- Reset mid-transaction: return to IDLE immediately. A late rvalid after reset is ignored. No lsu_doneM pulse.
- No throughput beyond one outstanding transaction.

Test Plan:
1. LW at 0x100, gnt in the issue cycle, rvalid=1 next cycle with rdata 0x12345678 → stallM 1,1,0; lsu_doneM pulses in the third cycle with lsu_rdataM=0x12345678; dbus_be=4'b1111.
2. LB at 0x203, rdata 0x80FF0000 → dbus_addr=0x200, be=4'b1000, lsu_rdataM=0xFFFFFF80. LBU at the same address → 0x00000080.
3. SH at 0x102, writedataM=0x0000ABCD → dbus_we=1, be=4'b1100, wdata=0xABCDABCD; write-ack rvalid → lsu_doneM=1, lsu_rdataM=0.
4. LW with gnt delayed 3 cycles, inputs changed while waiting → dbus_req/addr/be held constant for all 4 request cycles; stallM stays high until DONE.
5. LW at 0x1001 and LH at 0x1003 → excp_misalignM=1 the same cycle; dbus_req=0; stallM=0. LB at 0x1003 is not flagged.
6. Reset=0 asserted in WAIT, rvalid arrives 1 cycle after reset releases → state IDLE; no lsu_doneM; stallM=0. Two back-to-back LWs afterwards complete in 3+3 cycles.

Source files
------------

// File: rtl/cpu6_lsu.sv
// Memory-stage load/store unit: one data-bus transaction per memory op,
// stalls the pipeline until the response, then returns extended load data.
module cpu6_lsu #(
  parameter int XLEN   = 32,
  parameter int SIZE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwriteM,
  input  logic              memtoregM,
  input  logic [XLEN-1:0]   aluoutM,
  input  logic [XLEN-1:0]   writedataM,
  input  logic [SIZE_W-1:0] memsizeM,
  input  logic              memunsignedM,
  output logic              stallM,
  output logic              lsu_doneM,
  output logic [XLEN-1:0]   lsu_rdataM,
  output logic              excp_misalignM,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [XLEN-1:0]   dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [XLEN-1:0]   dbus_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic              memop;
  logic              misalign;
  logic              issue;
  logic [XLEN-1:0]   cap_addr;
  logic [XLEN-1:0]   cap_wdata;
  logic [3:0]        cap_be;
  logic [SIZE_W-1:0] cap_size;
  logic              cap_uns;
  logic              cap_we;
  logic [XLEN-1:0]   rdata_q;

  function automatic logic is_misaligned(input logic [SIZE_W-1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] calc_be(input logic [SIZE_W-1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   calc_be = 4'b0001 << off;
      2'b01:   calc_be = off[1] ? 4'b1100 : 4'b0011;
      default: calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] calc_wdata(input logic [SIZE_W-1:0] sz, input logic [XLEN-1:0] wd);
    case (sz)
      2'b00:   calc_wdata = {4{wd[7:0]}};
      2'b01:   calc_wdata = {2{wd[15:0]}};
      default: calc_wdata = wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] rd, input logic [1:0] off,
                                              input logic [SIZE_W-1:0] sz, input logic uns);
    logic [XLEN-1:0] sh;
    sh = rd >> {off, 3'b000};
    case (sz)
      2'b00:   extract = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  assign memop    = memwriteM | memtoregM;
  assign misalign = is_misaligned(memsizeM, aluoutM[1:0]);

  // Next-state and bus/pipeline outputs; IDLE drives the bus straight from the M inputs.
  always_comb begin
    next_state     = state;
    issue          = 1'b0;
    stallM         = 1'b0;
    lsu_doneM      = 1'b0;
    lsu_rdataM     = {XLEN{1'b0}};
    excp_misalignM = 1'b0;
    dbus_req       = 1'b0;
    dbus_we        = 1'b0;
    dbus_addr      = {XLEN{1'b0}};
    dbus_be        = 4'b0000;
    dbus_wdata     = {XLEN{1'b0}};
    case (state)
      ST_IDLE: begin
        if (memop && misalign) begin
          excp_misalignM = 1'b1;
        end else if (memop) begin
          issue      = 1'b1;
          stallM     = 1'b1;
          dbus_req   = 1'b1;
          dbus_we    = memwriteM;
          dbus_addr  = {aluoutM[XLEN-1:2], 2'b00};
          dbus_be    = calc_be(memsizeM, aluoutM[1:0]);
          dbus_wdata = calc_wdata(memsizeM, writedataM);
          next_state = dbus_gnt ? ST_WAIT : ST_REQ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        stallM     = 1'b1;
        dbus_req   = 1'b1;
        dbus_we    = cap_we;
        dbus_addr  = {cap_addr[XLEN-1:2], 2'b00};
        dbus_be    = cap_be;
        dbus_wdata = cap_wdata;
        if (dbus_gnt) begin
          next_state = ST_WAIT;
        end else begin
          next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        stallM = 1'b1;
        if (dbus_rvalid) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_DONE: begin
        lsu_doneM  = 1'b1;
        lsu_rdataM = rdata_q;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register, request capture and response data register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cap_addr  <= {XLEN{1'b0}};
      cap_wdata <= {XLEN{1'b0}};
      cap_be    <= 4'b0000;
      cap_size  <= {SIZE_W{1'b0}};
      cap_uns   <= 1'b0;
      cap_we    <= 1'b0;
      rdata_q   <= {XLEN{1'b0}};
    end else begin
      state <= next_state;
      if (issue) begin
        cap_addr  <= aluoutM;
        cap_wdata <= calc_wdata(memsizeM, writedataM);
        cap_be    <= calc_be(memsizeM, aluoutM[1:0]);
        cap_size  <= memsizeM;
        cap_uns   <= memunsignedM;
        cap_we    <= memwriteM;
      end
      // Stores complete with zero result data.
      if (state == ST_WAIT && dbus_rvalid) begin
        rdata_q <= cap_we ? {XLEN{1'b0}} : extract(dbus_rdata, cap_addr[1:0], cap_size, cap_uns);
      end
    end
  end

endmodule

// File: tb/tb_cpu6_lsu.sv
// Directed bench for cpu6_lsu: stimulus pushes expected completions into a
// queue, a negedge monitor pops and compares on lsu_doneM / excp_misalignM.
module tb_cpu6_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwriteM, memtoregM, memunsignedM;
  logic [31:0] aluoutM, writedataM;
  logic [1:0]  memsizeM;
  logic        stallM, lsu_doneM, excp_misalignM;
  logic [31:0] lsu_rdataM;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  typedef struct {
    logic        is_exc;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu6_lsu dut (
    .clk(clk), .reset(reset),
    .memwriteM(memwriteM), .memtoregM(memtoregM), .aluoutM(aluoutM),
    .writedataM(writedataM), .memsizeM(memsizeM), .memunsignedM(memunsignedM),
    .stallM(stallM), .lsu_doneM(lsu_doneM), .lsu_rdataM(lsu_rdataM),
    .excp_misalignM(excp_misalignM),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every completion or exception must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (lsu_doneM === 1'b1 || excp_misalignM === 1'b1) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: done=%b exc=%b rdata=%h at %0t",
                   lsu_doneM, excp_misalignM, lsu_rdataM, $time);
        end else begin
          e = expq.pop_front();
          chk("evt_kind", {30'd0, lsu_doneM, excp_misalignM}, {30'd0, ~e.is_exc, e.is_exc});
          if (!e.is_exc) chk("lsu_rdataM", lsu_rdataM, e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    memwriteM    = 1'b0;
    memtoregM    = 1'b0;
    memunsignedM = 1'b0;
    memsizeM     = 2'b00;
    aluoutM      = 32'h0;
    writedataM   = 32'h0;
    dbus_gnt     = 1'b0;
    dbus_rvalid  = 1'b0;
    dbus_rdata   = 32'h0;
  endtask

  // One full transaction: gd extra cycles before gnt, rvd extra WAIT cycles before rvalid.
  task automatic do_op(input string nm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                       input int gd, input int rvd, input logic [31:0] rd,
                       input logic [31:0] exp_data, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata);
    logic [31:0] exp_addr;
    exp_t e;
    exp_addr = {addr[31:2], 2'b00};
    @(posedge clk); #1;
    memwriteM = we; memtoregM = ~we; aluoutM = addr; writedataM = wd;
    memsizeM = sz; memunsignedM = uns;
    dbus_gnt = (gd == 0); dbus_rvalid = 1'b0;
    e.is_exc = 1'b0; e.data = exp_data;
    expq.push_back(e);
    for (int k = 0; k <= gd; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        aluoutM = 32'h0000_0ABC; memsizeM = 2'b00; memwriteM = ~we; writedataM = 32'h1111_2222;
        dbus_gnt = (k == gd);
      end
      @(negedge clk);
      chk({nm, ".req"},   {31'd0, dbus_req}, 32'd1);
      chk({nm, ".we"},    {31'd0, dbus_we}, {31'd0, we});
      chk({nm, ".addr"},  dbus_addr, exp_addr);
      chk({nm, ".be"},    {28'd0, dbus_be}, {28'd0, exp_be});
      chk({nm, ".wdata"}, dbus_wdata, exp_wdata);
      chk({nm, ".stall"}, {31'd0, stallM}, 32'd1);
    end
    for (int j = 0; j <= rvd; j++) begin
      @(posedge clk); #1;
      dbus_gnt = 1'b0;
      dbus_rvalid = (j == rvd);
      dbus_rdata = (j == rvd) ? rd : 32'hBAD0_BAD0;
      @(negedge clk);
      chk({nm, ".wait_req"},   {31'd0, dbus_req}, 32'd0);
      chk({nm, ".wait_stall"}, {31'd0, stallM}, 32'd1);
    end
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    chk({nm, ".done_stall"}, {31'd0, stallM}, 32'd0);
    chk({nm, ".done"},       {31'd0, lsu_doneM}, 32'd1);
    chk({nm, ".done_req"},   {31'd0, dbus_req}, 32'd0);
  endtask

  task automatic misalign_op(input string nm, input logic [31:0] addr, input logic [1:0] sz,
                             input logic flagged);
    exp_t e;
    @(posedge clk); #1;
    memtoregM = 1'b1; memwriteM = 1'b0; aluoutM = addr; memsizeM = sz; dbus_gnt = 1'b0;
    if (flagged) begin
      e.is_exc = 1'b1; e.data = 32'h0;
      expq.push_back(e);
    end
    @(negedge clk);
    chk({nm, ".exc"},   {31'd0, excp_misalignM}, {31'd0, flagged});
    chk({nm, ".req"},   {31'd0, dbus_req}, {31'd0, ~flagged});
    chk({nm, ".stall"}, {31'd0, stallM}, {31'd0, ~flagged});
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    exp_t e;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", {31'd0, stallM}, 32'd0);
    chk("rst.done",  {31'd0, lsu_doneM}, 32'd0);
    chk("rst.req",   {31'd0, dbus_req}, 32'd0);
    chk("rst.exc",   {31'd0, excp_misalignM}, 32'd0);
    chk("rst.rdata", lsu_rdataM, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: LW minimum latency
    do_op("lw100", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 0, 32'h12345678, 32'h12345678, 4'b1111, 32'h0);
    // 2: LB / LBU at 0x203
    do_op("lb203",  1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 0, 0, 32'h80FF0000, 32'hFFFFFF80, 4'b1000, 32'h0);
    do_op("lbu203", 1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 0, 0, 32'h80FF0000, 32'h00000080, 4'b1000, 32'h0);
    // halfword loads from the upper half
    do_op("lh102",  1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 0, 1, 32'h80011234, 32'hFFFF8001, 4'b1100, 32'h0);
    do_op("lhu102", 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 0, 0, 32'h80011234, 32'h00008001, 4'b1100, 32'h0);
    // 3: stores
    do_op("sh102", 1'b1, 32'h102, 32'h0000ABCD, 2'b01, 1'b0, 0, 0, 32'hDEADBEEF, 32'h0, 4'b1100, 32'hABCDABCD);
    do_op("sb101", 1'b1, 32'h101, 32'h1234565A, 2'b00, 1'b0, 0, 0, 32'hDEADBEEF, 32'h0, 4'b0010, 32'h5A5A5A5A);
    // reserved size acts as word
    do_op("lres104", 1'b0, 32'h104, 32'h0, 2'b11, 1'b0, 0, 0, 32'h0BADF00D, 32'h0BADF00D, 4'b1111, 32'h0);
    // 4: grant delayed three cycles with inputs changing underneath
    do_op("lwgnt", 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 3, 0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 32'h0);
    @(posedge clk); #1;
    idle_inputs();

    // 5: misalignment
    misalign_op("lw1001", 32'h1001, 2'b10, 1'b1);
    misalign_op("lh1003", 32'h1003, 2'b01, 1'b1);
    misalign_op("lb1003", 32'h1003, 2'b00, 1'b0);
    // LB at 0x1003 was issued with no grant; let it complete then go idle
    @(posedge clk); #1;
    memtoregM = 1'b1; aluoutM = 32'h1003; memsizeM = 2'b00; dbus_gnt = 1'b1;
    e.is_exc = 1'b0; e.data = 32'h0000007F;
    expq.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    dbus_rvalid = 1'b1; dbus_rdata = 32'h7F000000;
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("lb1003.done", {31'd0, lsu_doneM}, 32'd1);

    // 6: reset while waiting, late rvalid ignored
    @(posedge clk); #1;
    memtoregM = 1'b1; aluoutM = 32'h400; memsizeM = 2'b10; dbus_gnt = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    chk("rstw.stall_wait", {31'd0, stallM}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstw.stall_idle", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h55555555;
    @(negedge clk);
    chk("rstw.late_done",  {31'd0, lsu_doneM}, 32'd0);
    chk("rstw.late_stall", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("rstw.after_done", {31'd0, lsu_doneM}, 32'd0);
    do_op("b2b_a", 1'b0, 32'h500, 32'h0, 2'b10, 1'b0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'b1111, 32'h0);
    do_op("b2b_b", 1'b0, 32'h504, 32'h0, 2'b10, 1'b0, 0, 0, 32'h5A5A0001, 32'h5A5A0001, 4'b1111, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
